// File: rtl/ctrl_cabina_if.sv
// Sensor input register link for the cabin-safety controller.
// The controller (master) drives the sample strobe EN. The input register (slave)
// returns the registered Temp/Ca/Pre values that it captured on that strobe.
interface ctrl_cabina_if;
  logic       EN;    // one-cycle sample strobe to the register enable
  logic [4:0] Temp;  // registered temperature
  logic       Ca;    // registered ignition (1 = car on)
  logic       Pre;   // registered presence (1 = occupant detected)

  modport master (output EN, input Temp, Ca, Pre);
  modport slave  (input EN, output Temp, Ca, Pre);
endinterface

// File: rtl/ctrl_cabina.sv
// Cabin-safety controller.
// A free-running divider strobes the sensor input register every SAMPLE_DIV cycles.
// One cycle after each strobe the freshly registered sample is evaluated by a
// 4-state FSM. A saturating hot-sample counter makes the occupant alarm require
// PERSIST consecutive hot samples. Once raised, the alarm latches until the
// ignition comes on or the occupant leaves.
module ctrl_cabina #(
  parameter int         SAMPLE_DIV = 1000,  // cycles per sample period, >= 2
  parameter logic [4:0] T_HOT      = 5'd25, // Temp >= T_HOT is hot
  parameter int         PERSIST    = 3      // consecutive hot samples for alarm, >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_cabina_if.master        bus,
  output logic                 fan,
  output logic                 alarm,
  output logic [1:0]           state
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOT_W = $clog2(PERSIST + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  // EN is registered, so it is set one count early to be high while div_cnt == DIV_LAST.
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(SAMPLE_DIV - 2);
  localparam logic [HOT_W-1:0] HOT_MAX  = HOT_W'(PERSIST);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOL  = 2'b01,
    WATCH = 2'b10,
    ALARM = 2'b11
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             eval;
  logic [HOT_W-1:0] hot_cnt;
  state_t           state_q;

  logic             hot;
  logic [HOT_W-1:0] hot_inc;
  logic [HOT_W-1:0] hot_nxt;
  state_t           state_nxt;

  // Sample timer: wrap-around divider, registered EN strobe, and eval = EN delayed by one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    if (rst) begin
      div_cnt <= '0;
      bus.EN  <= 1'b0;
      eval    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      bus.EN  <= (div_cnt == DIV_PRE);
      eval    <= bus.EN;
    end
  end

  // Next-state and next hot count, from the registered sample (rules in priority order).
  always_comb begin
    // NOTE: every output of this block gets a default first. That way no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt = state_q;
    hot_nxt   = hot_cnt;
    hot       = (bus.Temp >= T_HOT);
    hot_inc   = (hot_cnt == HOT_MAX) ? HOT_MAX : hot_cnt + 1'b1;

    if (bus.Ca) begin
      // Ignition on overrides everything, including a latched alarm.
      state_nxt = hot ? COOL : IDLE;
      hot_nxt   = '0;
    end else if (!bus.Pre) begin
      // Nobody inside: nothing to protect.
      state_nxt = IDLE;
      hot_nxt   = '0;
    end else if (state_q == ALARM) begin
      // Occupant still present with ignition off: the alarm latches even if the cabin cools.
      state_nxt = ALARM;
    end else if (!hot) begin
      // A cool sample breaks the hot streak.
      state_nxt = IDLE;
      hot_nxt   = '0;
    end else begin
      // Another consecutive hot sample with an occupant and ignition off.
      hot_nxt   = hot_inc;
      state_nxt = (hot_inc >= HOT_MAX) ? ALARM : WATCH;
    end
  end

  // FSM register and registered fan/alarm outputs, updated only on eval cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hot_cnt <= '0;
      fan     <= 1'b0;
      alarm   <= 1'b0;
    end else if (eval) begin
      state_q <= state_nxt;
      hot_cnt <= hot_nxt;
      fan     <= (state_nxt == COOL) || (state_nxt == ALARM);
      alarm   <= (state_nxt == ALARM);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_cabina.sv
// Directed self-checking bench for ctrl_cabina (SAMPLE_DIV=4, T_HOT=25, PERSIST=3).
// It includes a behavioural model of the sensor input register that sits on the
// slave side of the interface.
module tb_ctrl_cabina;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic       fan;
  logic       alarm;
  logic [1:0] state;

  // Raw sensor values presented to the input register.
  logic [4:0] s_temp;
  logic       s_ca;
  logic       s_pre;

  int total;
  int bad;

  ctrl_cabina_if bus ();

  ctrl_cabina #(
    .SAMPLE_DIV (SD),
    .T_HOT      (5'd25),
    .PERSIST    (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .fan   (fan),
    .alarm (alarm),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input register model: captures the sensors on an EN edge, holds otherwise, and clears on reset.
  always @(posedge clk) begin
    if (rst) begin
      bus.Temp <= 5'd0;
      bus.Ca   <= 1'b0;
      bus.Pre  <= 1'b0;
    end else if (bus.EN) begin
      bus.Temp <= s_temp;
      bus.Ca   <= s_ca;
      bus.Pre  <= s_pre;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compares state/fan/alarm against hand-derived values for an expected state.
  task automatic expect_out(input string tag, input logic [1:0] es, input logic ef, input logic ea);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".fan"},   32'(fan),   32'(ef));
    check({tag, ".alarm"}, 32'(alarm), 32'(ea));
  endtask

  task automatic set_sensors(input logic ca, input logic pre, input logic [4:0] t);
    s_ca   = ca;
    s_pre  = pre;
    s_temp = t;
  endtask

  // Advances to the next negedge with EN high (bounded). Then it moves two more
  // cycles, to where the outputs reflect that sample.
  task automatic next_sample(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * SD && !found; i++) begin
      @(negedge clk);
      if (bus.EN === 1'b1) found = 1'b1;
    end
    check({tag, ".en_seen"}, 32'(found), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_sensors(1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cycle 0 is now current. EN is a single pulse every 4 cycles; the outputs stay idle.
    for (int k = 0; k < 20; k++) begin
      check($sformatf("idle_en_c%0d", k), 32'(bus.EN), 32'((k % SD) == SD - 1));
      expect_out($sformatf("idle_c%0d", k), 2'b00, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Ignition with Temp exactly at the threshold -> COOL, fan on.
    set_sensors(1'b1, 1'b0, 5'd25);
    next_sample("ign_hot");
    expect_out("ign_hot", 2'b01, 1'b1, 1'b0);
    // One below the threshold is not hot -> IDLE.
    set_sensors(1'b1, 1'b0, 5'd24);
    next_sample("ign_cool");
    expect_out("ign_cool", 2'b00, 1'b0, 1'b0);

    // Persistence: three hot samples with the occupant present and ignition off.
    set_sensors(1'b0, 1'b1, 5'd30);
    next_sample("pers1");
    expect_out("pers1", 2'b10, 1'b0, 1'b0);
    next_sample("pers2");
    expect_out("pers2", 2'b10, 1'b0, 1'b0);
    next_sample("pers3");
    expect_out("pers3", 2'b11, 1'b1, 1'b1);

    // Alarm latches through a temperature drop.
    set_sensors(1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 3; i++) begin
      next_sample($sformatf("latch%0d", i));
      expect_out($sformatf("latch%0d", i), 2'b11, 1'b1, 1'b1);
    end
    // Occupant leaves -> IDLE.
    set_sensors(1'b0, 1'b0, 5'd10);
    next_sample("leave");
    expect_out("leave", 2'b00, 1'b0, 1'b0);

    // Hot streak broken after two samples; the count restarts from zero.
    set_sensors(1'b0, 1'b1, 5'd30);
    next_sample("brk1");
    expect_out("brk1", 2'b10, 1'b0, 1'b0);
    next_sample("brk2");
    expect_out("brk2", 2'b10, 1'b0, 1'b0);
    set_sensors(1'b0, 1'b1, 5'd20);
    next_sample("brk_cool");
    expect_out("brk_cool", 2'b00, 1'b0, 1'b0);
    set_sensors(1'b0, 1'b1, 5'd30);
    next_sample("rehot1");
    expect_out("rehot1", 2'b10, 1'b0, 1'b0);
    next_sample("rehot2");
    expect_out("rehot2", 2'b10, 1'b0, 1'b0);
    next_sample("rehot3");
    expect_out("rehot3", 2'b11, 1'b1, 1'b1);

    // Ignition overrides the latched alarm.
    set_sensors(1'b1, 1'b1, 5'd30);
    next_sample("override");
    expect_out("override", 2'b01, 1'b1, 1'b0);

    // From COOL the first hot sample counts as the first in the streak.
    set_sensors(1'b0, 1'b1, 5'd30);
    next_sample("from_cool1");
    expect_out("from_cool1", 2'b10, 1'b0, 1'b0);
    next_sample("from_cool2");
    expect_out("from_cool2", 2'b10, 1'b0, 1'b0);
    next_sample("from_cool3");
    expect_out("from_cool3", 2'b11, 1'b1, 1'b1);

    // Mid-operation reset in ALARM, asserted in an eval cycle (reset wins).
    next_sample("pre_rst");
    expect_out("pre_rst", 2'b11, 1'b1, 1'b1);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 3 * SD && !found; i++) begin
        @(negedge clk);
        if (bus.EN === 1'b1) found = 1'b1;
      end
      check("rst_en_seen", 32'(found), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_out("rst_c0", 2'b00, 1'b0, 1'b0);
    check("rst_en_c0", 32'(bus.EN), 32'd0);
    for (int k = 1; k < SD; k++) begin
      @(negedge clk);
      check($sformatf("rst_en_c%0d", k), 32'(bus.EN), 32'(k == SD - 1));
    end
    @(negedge clk);
    expect_out("rst_c4", 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("post_rst1", 2'b10, 1'b0, 1'b0);
    next_sample("post_rst2");
    expect_out("post_rst2", 2'b10, 1'b0, 1'b0);
    next_sample("post_rst3");
    expect_out("post_rst3", 2'b11, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
